regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters: the in-order pipeline WB stage and a long-latency unit (multiplier/divider, deferred load) with a FIFO queue.
- Pipeline WB has priority by default. A starvation counter forces a queued write through and stalls the pipeline for one cycle.
- Exports a per-register pending mask so the decode hazard unit can stall readers and writers of queued destinations.
- Sits between the WB stage / long-latency unit and the register file write port. The register file writes on negedge clk.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 4, long-latency write queue entries (power of 2, >=2)
- STARVE_MAX, 8, cycles a non-empty queue may be denied before forced grant

Ports:
- clk  in  1  clock; arbiter state updates on posedge
- reset  in  1  asynchronous, active-low
- wb_valid  in  1  pipeline WB write request this cycle
- wb_addr  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- lu_valid  in  1  long-latency unit write request
- lu_ready  out  1  queue can accept (count < FIFO_DEPTH)
- lu_addr  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency write data
- pipe_stall  out  1  pipeline must hold WB this cycle
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)
- pending_mask  out  2**ADDR_W  bit i set while any queued entry targets register i
- fifo_count  out  clog2(FIFO_DEPTH)+1  current queue occupancy

Behaviour:
- Reset (reset=0, asynchronous, may occur mid-operation):
  - Immediately clears rf_we, rf_waddr, rf_wdata, queue pointers, count and starve_cnt.
  - pending_mask=0, pipe_stall=0, lu_ready=1.
  - In-flight queued writes are discarded.
- Queue push: lu_valid && lu_ready at posedge enqueues {lu_addr, lu_data}.
  - lu_ready is purely combinational from count.
  - No push when full; lu_valid held with lu_ready=0 must not be lost or duplicated.
- force = (starve_cnt == STARVE_MAX) && (count != 0). pipe_stall = force (combinational).
- Grant selection each cycle:
  - force=1: grant queue head; WB request ignored. The pipeline holds wb_* stable and re-presents them next cycle.
  - force=0 and wb_valid=1: grant WB.
  - force=0, wb_valid=0, count!=0: grant queue head.
  - Otherwise: no grant.
- Output register: at posedge, rf_we <= (grant exists) && (granted addr != 0), and rf_waddr/rf_wdata <= granted addr/data.
  - The register file samples them at the following negedge. Latency: request at posedge N -> written at negedge in cycle N+1.
  - Writes to register 0 are dropped (rf_we=0) but still consume the grant: a queue pop, or WB completion.
- Queue pop: occurs on every queue grant. Simultaneous push and pop is allowed, including when full (lu_ready still 0 while full, so no push that cycle). Count is unchanged on push+pop.
- Pointers wrap modulo FIFO_DEPTH.
- starve_cnt:
  - Cleared on queue grant or when count==0.
  - Increments by 1 when count!=0 and WB was granted.
  - Saturates at STARVE_MAX.
- pending_mask: combinational OR of one-hot decode over valid queue entries. Entries with addr 0 never set bit 0.
- Ordering: the arbiter never reorders within the queue. Same-register ordering between WB and the queue is the hazard unit's duty via pending_mask; the arbiter does not check it.
- Simultaneous WB and queue pop to the same address can only occur under a hazard-unit failure. The granted source wins; no error flag.

Test Plan:
- Reset mid-queue: push 3 entries (regs 5,6,7), assert reset=0 between edges -> rf_we=0 immediately, fifo_count=0, pending_mask=0, lu_ready=1.
- Idle pipeline: wb_valid=0, push {r9, 0xDEADBEEF} -> next posedge rf_we=1, rf_waddr=9, rf_wdata=0xDEADBEEF; pending_mask[9] clears after pop.
- WB priority plus starvation: queue holds r3, wb_valid=1 every cycle.
  - The first 8 cycles grant WB; starve_cnt reaches 8.
  - Then pipe_stall=1 for exactly one cycle and r3 is written; the held WB is written the following cycle.
- Full queue: push 4 entries with wb_valid=1 -> lu_ready=0, fifo_count=4. A 5th lu_valid held until a pop, then accepted exactly once.
- Register zero: WB to r0 and a queued write to r0 -> rf_we never asserts. The queue entry still pops; fifo_count decrements.
- Pointer wrap: 10 push/pop pairs through a depth-4 queue with mixed WB traffic -> all writes appear in FIFO order with correct data.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the WB, long-latency and register-file write-port signals around the
// write-port arbiter. The arbiter binds to the slave modport; the surrounding pipeline binds to master.
interface regfile_wport_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int NREG  = 2 ** ADDR_W;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              pipe_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [NREG-1:0]   pending_mask;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        output lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, pending_mask, fifo_count
    );

    modport master (
        output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        input  lu_ready, pipe_stall, rf_we, rf_waddr, rf_wdata, pending_mask, fifo_count
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between the WB stage (priority) and a queued
// long-latency unit, with a starvation override and a pending-destination mask.
module regfile_wport_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_wport_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_QUEUE} grant_e;

    logic [ADDR_W-1:0] r_q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_lu_ready;
    logic              w_q_nonempty;
    logic              w_force;
    logic              w_push;
    logic              w_pop;
    grant_e            w_grant;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;
    logic [NREG-1:0]   w_pending;

    assign w_lu_ready   = r_count < CNT_W'(FIFO_DEPTH);
    assign w_q_nonempty = r_count != '0;
    assign w_force      = (r_starve_cnt == SC_W'(STARVE_MAX)) && w_q_nonempty;
    assign w_push       = bus.lu_valid && w_lu_ready;
    assign w_pop        = w_grant == GNT_QUEUE;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_grant    = GNT_NONE;
        w_gnt_addr = '0;
        w_gnt_data = '0;
        if (w_force)
            w_grant = GNT_QUEUE;
        else if (bus.wb_valid)
            w_grant = GNT_WB;
        else if (w_q_nonempty)
            w_grant = GNT_QUEUE;

        case (w_grant)
            GNT_WB: begin
                w_gnt_addr = bus.wb_addr;
                w_gnt_data = bus.wb_data;
            end
            GNT_QUEUE: begin
                w_gnt_addr = r_q_addr[r_rd_ptr];
                w_gnt_data = r_q_data[r_rd_ptr];
            end
            default: ;
        endcase
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count) && (r_q_addr[i] != '0))
                w_pending[r_q_addr[i]] = 1'b1;
        end
    end

    // NOTE: queue storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= bus.lu_addr;
            r_q_data[r_wr_ptr] <= bus.lu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_starve_cnt <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_pop || !w_q_nonempty)
                r_starve_cnt <= '0;
            else if ((w_grant == GNT_WB) && (r_starve_cnt != SC_W'(STARVE_MAX)))
                r_starve_cnt <= r_starve_cnt + 1'b1;

            // Register 0 writes still consume their grant but never reach the file.
            r_rf_we <= (w_grant != GNT_NONE) && (w_gnt_addr != '0);
            if (w_grant != GNT_NONE) begin
                r_rf_waddr <= w_gnt_addr;
                r_rf_wdata <= w_gnt_data;
            end
        end
    end

    assign bus.lu_ready     = w_lu_ready;
    assign bus.pipe_stall   = w_force;
    assign bus.rf_we        = r_rf_we;
    assign bus.rf_waddr     = r_rf_waddr;
    assign bus.rf_wdata     = r_rf_wdata;
    assign bus.pending_mask = w_pending;
    assign bus.fifo_count   = r_count;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: reset, idle drain, starvation override,
// full-queue backpressure, register-zero drops and pointer wrap ordering.
module tb_regfile_wport_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    regfile_wport_arbiter_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) bus ();

    regfile_wport_arbiter #(
        .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_MAX(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench did not terminate");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.wb_valid = v;
        bus.wb_addr  = a;
        bus.wb_data  = d;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lu_valid = v;
        bus.lu_addr  = a;
        bus.lu_data  = d;
    endtask

    logic [31:0] sb [$];
    logic [31:0] exp_d;
    logic [7:0]  pat;
    int          p;
    int          cyc;
    int          wb_exp;
    int          wb_seen;
    bit          acc_lu;
    bit          acc_wb;

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive_wb(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", bus.rf_we, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_pending", bus.pending_mask, 0);
        check("rst_lu_ready", bus.lu_ready, 1);
        check("rst_stall", bus.pipe_stall, 0);
        reset = 1'b1;
        tick();

        // Reset mid-queue: r5,r6,r7 queued behind continuous WB traffic to r1
        drive_wb(1'b1, 5'd1, 32'h0000_0111);
        drive_lu(1'b1, 5'd5, 32'h55);
        tick();
        drive_lu(1'b1, 5'd6, 32'h66);
        tick();
        drive_lu(1'b1, 5'd7, 32'h77);
        tick();
        drive_wb(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        check("midq_count", bus.fifo_count, 3);
        check("midq_pending", bus.pending_mask, 32'h0000_00E0);
        check("midq_rf_we", bus.rf_we, 1);
        #3;
        reset = 1'b0;
        #1;
        check("midq_rst_rf_we", bus.rf_we, 0);
        check("midq_rst_count", bus.fifo_count, 0);
        check("midq_rst_pending", bus.pending_mask, 0);
        check("midq_rst_lu_ready", bus.lu_ready, 1);
        tick();
        reset = 1'b1;
        tick();
        check("midq_post_rf_we", bus.rf_we, 0);

        // Idle pipeline: a queued write drains on the next edge
        drive_lu(1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        drive_lu(1'b0, '0, '0);
        check("idle_pending_set", bus.pending_mask, 32'h0000_0200);
        check("idle_count1", bus.fifo_count, 1);
        check("idle_rf_we0", bus.rf_we, 0);
        tick();
        check("idle_rf_we", bus.rf_we, 1);
        check("idle_waddr", bus.rf_waddr, 9);
        check("idle_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        check("idle_pending_clr", bus.pending_mask, 0);
        check("idle_count0", bus.fifo_count, 0);

        // Starvation: r3 queued, WB requests every cycle
        drive_wb(1'b1, 5'd10, 32'd100);
        drive_lu(1'b1, 5'd3, 32'h33);
        tick();
        drive_lu(1'b0, '0, '0);
        check("starve_wb0_addr", bus.rf_waddr, 10);
        for (int k = 1; k <= 8; k++) begin
            drive_wb(1'b1, 5'd10, 32'(100 + k));
            check("starve_no_stall", bus.pipe_stall, 0);
            tick();
            check("starve_wb_data", bus.rf_wdata, 64'(100 + k));
        end
        drive_wb(1'b1, 5'd10, 32'd200);
        check("starve_stall", bus.pipe_stall, 1);
        tick();
        check("starve_q_addr", bus.rf_waddr, 3);
        check("starve_q_data", bus.rf_wdata, 32'h33);
        check("starve_stall_drop", bus.pipe_stall, 0);
        check("starve_count", bus.fifo_count, 0);
        tick();
        check("starve_held_addr", bus.rf_waddr, 10);
        check("starve_held_data", bus.rf_wdata, 200);

        // Full queue: four pushes under WB pressure, a fifth held until a pop
        drive_wb(1'b1, 5'd11, 32'hBB);
        for (int k = 12; k <= 15; k++) begin
            drive_lu(1'b1, 5'(k), 32'h1000_0000 + 32'(k));
            tick();
        end
        check("full_count", bus.fifo_count, 4);
        check("full_lu_ready", bus.lu_ready, 0);
        check("full_pending", bus.pending_mask, 32'h0000_F000);
        drive_lu(1'b1, 5'd16, 32'h1000_0010);
        tick();
        check("full_hold_count1", bus.fifo_count, 4);
        tick();
        check("full_hold_count2", bus.fifo_count, 4);
        check("full_hold_ready", bus.lu_ready, 0);
        drive_wb(1'b0, '0, '0);
        tick();
        check("full_pop1_addr", bus.rf_waddr, 12);
        check("full_pop1_data", bus.rf_wdata, 32'h1000_000C);
        check("full_pop1_count", bus.fifo_count, 3);
        check("full_pop1_ready", bus.lu_ready, 1);
        tick();
        drive_lu(1'b0, '0, '0);
        check("full_pop2_addr", bus.rf_waddr, 13);
        check("full_pushpop_count", bus.fifo_count, 3);
        check("full_pending2", bus.pending_mask, 32'h0001_C000);
        tick();
        check("full_pop3_addr", bus.rf_waddr, 14);
        tick();
        check("full_pop4_addr", bus.rf_waddr, 15);
        tick();
        check("full_pop5_addr", bus.rf_waddr, 16);
        check("full_pop5_data", bus.rf_wdata, 32'h1000_0010);
        check("full_drained", bus.fifo_count, 0);
        tick();
        check("full_no_dup", bus.rf_we, 0);

        // Register zero: both sources target r0, nothing is written
        drive_wb(1'b1, 5'd0, 32'hAA);
        drive_lu(1'b1, 5'd0, 32'hCC);
        tick();
        drive_wb(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        check("r0_wb_we", bus.rf_we, 0);
        check("r0_count1", bus.fifo_count, 1);
        check("r0_pending", bus.pending_mask, 0);
        tick();
        check("r0_q_we", bus.rf_we, 0);
        check("r0_count0", bus.fifo_count, 0);

        // Pointer wrap: 10 queued writes interleaved with WB traffic to r2
        pat     = 8'b0010_1101;
        p       = 0;
        cyc     = 0;
        wb_exp  = 0;
        wb_seen = 0;
        while ((p < 10 || sb.size() != 0) && cyc < 80) begin
            drive_lu(p < 10, 5'(17 + p % 8), 32'hA500_0000 + 32'(p));
            drive_wb(pat[cyc % 8], 5'd2, 32'hB000_0000 + 32'(cyc));
            #1;
            acc_lu = bus.lu_valid && bus.lu_ready;
            acc_wb = bus.wb_valid && !bus.pipe_stall;
            tick();
            if (acc_wb)
                wb_exp++;
            if (bus.rf_we) begin
                if (bus.rf_waddr == 5'd2) begin
                    wb_seen++;
                end else if (sb.size() == 0) begin
                    check("wrap_extra_write", bus.rf_waddr, 0);
                end else begin
                    exp_d = sb.pop_front();
                    check("wrap_data", bus.rf_wdata, exp_d);
                    check("wrap_addr", bus.rf_waddr, 64'(17 + exp_d[7:0] % 8));
                end
            end
            if (acc_lu) begin
                sb.push_back(32'hA500_0000 + 32'(p));
                p++;
            end
            cyc++;
        end
        drive_wb(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        check("wrap_in_budget", cyc < 80, 1);
        check("wrap_all_pushed", p, 10);
        check("wrap_wb_count", wb_seen, wb_exp);
        check("wrap_count0", bus.fifo_count, 0);
        check("wrap_pending0", bus.pending_mask, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
